dfr_pipe: RTL and testbench
===========================

// Module: dfr_pipe
// PURPOSE
//   Parametrised successor to the single-bit reset flop: a WIDTH-bit, DEPTH-stage
//   register pipeline with a per-stage valid bit, valid/ready backpressure,
//   bubble collapsing, synchronous flush and an occupancy count.
//   Used wherever a datapath needs retiming stages that can stall without
//   dropping or duplicating data, e.g. between benchmark arithmetic blocks.
// PARAMETERS
//   WIDTH      8    data width in bits (>=1)
//   DEPTH      3    number of register stages (>=1)
//   RESET_VAL  0    WIDTH-bit value loaded into every data stage on reset
// PORTS
//   clk        in   1                   clock, rising edge
//   reset      in   1                   async, active-high reset
//   flush      in   1                   sync clear of all valid bits
//   in_data    in   WIDTH               upstream data
//   in_valid   in   1                   upstream data valid
//   in_ready   out  1                   pipeline can accept in_data this cycle
//   out_data   out  WIDTH               data of last stage
//   out_valid  out  1                   last stage holds valid data
//   out_ready  in   1                   downstream accepts out_data this cycle
//   count      out  $clog2(DEPTH+1)     number of valid stages
// BEHAVIOUR
//   - Stage k holds v[k], d[k]; stage 0 is the input end, stage DEPTH-1 drives out_*.
//   - Reset (async, immediate): v[*]=0, d[*]=RESET_VAL, so out_valid=0,
//     out_data=RESET_VAL, count=0, in_ready=1. Reset mid-stream discards all data.
//   - Ready chain (combinational): rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready;
//     rdy[k] = ~v[k] | rdy[k+1]. in_ready = rdy[0] & ~flush.
//   - Clock edge, no flush: for each k with rdy[k]: v[k] <= v[k-1] (in_valid for k=0).
//     d[k] <= d[k-1] (in_data for k=0) only when the upstream valid is 1; otherwise
//     d[k] holds. Stages with rdy[k]=0 hold v and d.
//   - Bubbles collapse: an empty stage always accepts, even while downstream stalls.
//   - Transfers: input accepted iff in_valid & in_ready; output consumed iff
//     out_valid & out_ready. Both may happen in the same cycle, incl. when full.
//   - Latency DEPTH cycles from accept to out_valid with out_ready held 1;
//     throughput one word per cycle; never drops, duplicates or reorders data.
//   - Full (count==DEPTH) & out_ready=0: in_ready=0, all stages hold.
//     Full & out_ready=1: in_ready=1, simultaneous pop and push, count unchanged.
//   - Empty: out_valid=0; out_data holds last value (not meaningful).
//   - count is registered: count_next = count + push - pop, never exceeds DEPTH.
//   - flush=1: in_ready=0, out_valid forced 0 this cycle (no output transfer),
//     next edge v[*]=0, count=0; d[*] retained. Reset overrides flush.
//   - in_valid must stay stable (data held) until accepted; the block does not check this.
// TESTING
//   1 WIDTH=8 DEPTH=3, push 0x11,0x22,0x33 back-to-back, out_ready=1 -> out_valid
//     first 3 cycles after 0x11 accepted; outputs 0x11,0x22,0x33 on consecutive cycles.
//   2 out_ready=0, push 4 words -> first 3 accepted, count=3, in_ready=0; raise
//     out_ready -> 4th accepted same cycle first word pops, order preserved.
//   3 Push 0xA1, gap 2 cycles, push 0xA2 with out_ready=0 -> both collapse to last
//     two stages, count=2; release -> 0xA1 then 0xA2 on consecutive cycles.
//   4 Full pipe, assert flush 1 cycle with in_valid=1 -> in_ready=0, out_valid=0,
//     next cycle count=0, no word ever appears at output.
//   5 Assert reset mid-stream (between clock edges) -> out_valid=0,
//     out_data=RESET_VAL, count=0 immediately; stream restarts cleanly after release.
//   6 DEPTH=1, in_valid=1 and out_ready=1 continuous -> one word/cycle, count=1.

Source files
------------

// File: rtl/dfr_pipe.sv
// dfr_pipe: WIDTH x DEPTH valid/ready register pipeline
// with bubble collapsing, synchronous flush and occupancy count.
module dfr_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic             push;
  logic             pop;

  // Ready ripples from the output end; an empty stage always accepts.
  always_comb begin
    logic r;
    r = ~v[DEPTH-1] | out_ready;
    rdy = '0;
    rdy[DEPTH-1] = r;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r = ~v[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign count     = cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic             uv;
    logic [WIDTH-1:0] ud;
    logic             vq;
    logic [WIDTH-1:0] dq;

    if (k == 0) begin : g_head
      assign uv = in_valid;
      assign ud = in_data;
    end else begin : g_link
      assign uv = v[k-1];
      assign ud = d[k-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vq <= 1'b0;
        dq <= RESET_VAL;
      end else if (flush) begin
        vq <= 1'b0;
      end else if (rdy[k]) begin
        vq <= uv;
        if (uv) dq <= ud;
      end
    end

    assign v[k] = vq;
    assign d[k] = dq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (flush) cnt_q <= '0;
    else            cnt_q <= cnt_q + CW'(push) - CW'(pop);
  end

endmodule

// File: tb/tb_dfr_pipe.sv
// tb_dfr_pipe: table-driven check of dfr_pipe (DEPTH=3)
// plus hand sequences for reset and DEPTH=1.
module tb_dfr_pipe;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  logic       b_flush;
  logic [7:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [0:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] RV = 8'h5A;

  dfr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  dfr_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       chk_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy,
                              logic fl, logic e_ir, logic e_ov,
                              logic [7:0] e_od, logic chk_od,
                              logic [1:0] e_cnt);
    vec_t t;
    t.iv = iv; t.id = id; t.ordy = ordy; t.fl = fl;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od;
    t.chk_od = chk_od; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one row, check before the next edge, then take the edge.
  task automatic run_vec(vec_t t, int idx);
    string s;
    in_valid  = t.iv;
    in_data   = t.id;
    out_ready = t.ordy;
    flush     = t.fl;
    @(negedge clk);
    s = $sformatf("row%0d", idx);
    chk({s, ".in_ready"}, 32'(in_ready), 32'(t.e_ir));
    chk({s, ".out_valid"}, 32'(out_valid), 32'(t.e_ov));
    chk({s, ".count"}, 32'(count), 32'(t.e_cnt));
    if (t.chk_od) chk({s, ".out_data"}, 32'(out_data), 32'(t.e_od));
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) run_vec(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0;
    b_flush = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'(RV));
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // back-to-back, latency DEPTH
    tbl.push_back(mk(1, 8'h11, 1, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h22, 1, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 8'h33, 1, 0, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h11, 1, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h22, 1, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    // fill while stalled, then push+pop when full
    tbl.push_back(mk(1, 8'h41, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h42, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 8'h43, 0, 0, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(1, 8'h44, 0, 0, 0, 1, 8'h41, 1, 3));
    tbl.push_back(mk(1, 8'h44, 1, 0, 1, 1, 8'h41, 1, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h42, 1, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h43, 1, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    // bubble collapse under stall
    tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 8'hA1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA1, 1, 2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA2, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    // flush a full pipe
    tbl.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hB2, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 8'hB3, 0, 0, 1, 0, 8'h00, 0, 2));
    tbl.push_back(mk(1, 8'hB4, 1, 1, 0, 0, 8'h00, 0, 3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    // partial fill ahead of a mid-cycle reset
    tbl.push_back(mk(1, 8'hC1, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hC2, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2));
    run_tbl();

    in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b0;
    #2;
    chk("pre_rst.count", 32'(count), 32'd2);
    chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst.out_data", 32'(out_data), 32'hC1);
    reset = 1'b1;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_data", 32'(out_data), 32'(RV));
    chk("mid_rst.count", 32'(count), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    tbl.push_back(mk(1, 8'hD1, 1, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hD1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0));
    run_tbl();

    // DEPTH=1 streaming at full rate
    b_in_valid = 1'b1; b_out_ready = 1'b1; b_in_data = 8'h60;
    @(negedge clk);
    chk("d1.init.count", 32'(b_count), 32'd0);
    chk("d1.init.out_valid", 32'(b_out_valid), 32'd0);
    chk("d1.init.in_ready", 32'(b_in_ready), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      b_in_data = 8'(8'h60 + i);
      @(negedge clk);
      chk($sformatf("d1.c%0d.out_valid", i), 32'(b_out_valid), 32'd1);
      chk($sformatf("d1.c%0d.out_data", i), 32'(b_out_data),
          32'(8'h60 + i - 1));
      chk($sformatf("d1.c%0d.count", i), 32'(b_count), 32'd1);
      chk($sformatf("d1.c%0d.in_ready", i), 32'(b_in_ready), 32'd1);
    end
    b_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
